// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Shares the single result-writeback bus (CDB) between the ALU, LSB and MUL.
// Each producer pushes results into its own small circular FIFO through a
// valid/ready handshake. A round-robin scheduler pops at most one FIFO head
// per cycle onto a registered CDB. A rollback empties every FIFO and drops
// that cycle's inputs. When rdy is low, all state is frozen.
//
// Optional build macro:
//   CDB_BYPASS_EN - a source that wins arbitration with an empty FIFO but with
//                   an accepted input has that input registered straight onto
//                   the CDB. The input is not written to the FIFO.
//                   When the macro is not defined, every result passes
//                   through its FIFO.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes all state
//   rollback            misprediction flush
//   alu_*               ALU producer (valid/ready, rob entry, value, jump info)
//   lsb_*               LSB producer (valid/ready, rob entry, value)
//   mul_*               MUL producer (valid/ready, rob entry, value)
//   cdb_*               registered broadcast (valid, source, entry, value,
//                       jump info; jump fields are 0 for LSB/MUL)
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int ROB_IDX_W  = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,

  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [ROB_IDX_W-1:0] alu_rob_entry,
  input  logic [31:0]          alu_val,
  input  logic                 alu_need_jump,
  input  logic [31:0]          alu_jump_pc,

  input  logic                 lsb_valid,
  output logic                 lsb_ready,
  input  logic [ROB_IDX_W-1:0] lsb_rob_entry,
  input  logic [31:0]          lsb_value,

  input  logic                 mul_valid,
  output logic                 mul_ready,
  input  logic [ROB_IDX_W-1:0] mul_rob_entry,
  input  logic [31:0]          mul_val,

  output logic                 cdb_valid,
  output logic [1:0]           cdb_src,
  output logic [ROB_IDX_W-1:0] cdb_rob_entry,
  output logic [31:0]          cdb_value,
  output logic                 cdb_need_jump,
  output logic [31:0]          cdb_jump_pc
);

  localparam int               NSRC     = 3;
  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam int               CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_entry;
    logic [31:0]          value;
    logic                 need_jump;
    logic [31:0]          jump_pc;
  } entry_t;

  // Source index 0 = ALU, 1 = LSB, 2 = MUL (matches the cdb_src encoding).
  entry_t            mem_q    [NSRC][FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q [NSRC];
  logic [PTR_W-1:0]  rd_ptr_d [NSRC];
  logic [PTR_W-1:0]  wr_ptr_q [NSRC];
  logic [PTR_W-1:0]  wr_ptr_d [NSRC];
  logic [CNT_W-1:0]  count_q  [NSRC];
  logic [CNT_W-1:0]  count_d  [NSRC];
  logic [1:0]        rr_q, rr_d;

  logic              cdb_valid_q, cdb_valid_d;
  logic [1:0]        cdb_src_q,   cdb_src_d;
  entry_t            cdb_entry_q, cdb_entry_d;

  entry_t            in_entry [NSRC];
  logic [NSRC-1:0]   in_valid;
  logic [NSRC-1:0]   ready;
  logic [NSRC-1:0]   push_req;
  logic [NSRC-1:0]   offer;
  logic [NSRC-1:0]   cand;
  logic [NSRC-1:0]   grant_oh;
  logic [NSRC-1:0]   push;
  logic [NSRC-1:0]   pop;
  logic              grant_valid;
  logic              bypass_sel;
  logic [1:0]        grant_idx;
  entry_t            grant_entry;
  logic              active;

  // ---------------------------------------------------------------------------
  // Input packing. LSB and MUL never carry jump information.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_entry[0] = '{rob_entry: alu_rob_entry, value: alu_val,
                    need_jump: alu_need_jump, jump_pc: alu_jump_pc};
    in_entry[1] = '{rob_entry: lsb_rob_entry, value: lsb_value,
                    need_jump: 1'b0, jump_pc: 32'd0};
    in_entry[2] = '{rob_entry: mul_rob_entry, value: mul_val,
                    need_jump: 1'b0, jump_pc: 32'd0};
    in_valid    = {mul_valid, lsb_valid, alu_valid};
  end

  // Ready is based on the pre-pop count, so a full FIFO refuses input even in
  // the cycle it is being drained.
  assign active = rdy && !rollback;

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      ready[i] = (count_q[i] != FULL_CNT) && active;
    end
  end

  assign push_req  = in_valid & ready;
  assign alu_ready = ready[0];
  assign lsb_ready = ready[1];
  assign mul_ready = ready[2];

  // ---------------------------------------------------------------------------
  // Round-robin grant: scan rr, rr+1, rr+2 (mod 3); the first candidate wins.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in a combinational block gets a default at the
  // top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_oh    = '0;
    grant_idx   = 2'd0;
    grant_valid = 1'b0;
    bypass_sel  = 1'b0;
    grant_entry = '0;
`ifdef CDB_BYPASS_EN
    offer       = push_req;
`else
    offer       = '0;
`endif
    for (int i = 0; i < NSRC; i++) begin
      cand[i] = active && ((count_q[i] != '0) || offer[i]);
    end
    for (int k = 0; k < NSRC; k++) begin
      for (int i = 0; i < NSRC; i++) begin
        if (!grant_valid && cand[i] && (i == (int'(rr_q) + k) % NSRC)) begin
          grant_valid = 1'b1;
          grant_oh[i] = 1'b1;
          grant_idx   = 2'(i);
          // A non-empty FIFO always sends its head. Only an empty one can
          // forward its input.
          bypass_sel  = (count_q[i] == '0);
          grant_entry = bypass_sel ? in_entry[i] : mem_q[i][rd_ptr_q[i]];
        end
      end
    end
  end

  // A bypassed input goes onto the CDB and is not written to the FIFO.
  assign push = push_req & ~(grant_oh & {NSRC{bypass_sel}});
  assign pop  = grant_oh & ~{NSRC{bypass_sel}};

  // ---------------------------------------------------------------------------
  // Next state. rollback has priority over rdy. rst is handled in the
  // register block.
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_d        = rr_q;
    cdb_valid_d = cdb_valid_q;
    cdb_src_d   = cdb_src_q;
    cdb_entry_d = cdb_entry_q;
    for (int i = 0; i < NSRC; i++) begin
      rd_ptr_d[i] = rd_ptr_q[i];
      wr_ptr_d[i] = wr_ptr_q[i];
      count_d[i]  = count_q[i];
    end

    if (rollback) begin
      rr_d        = 2'd0;
      cdb_valid_d = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
        rd_ptr_d[i] = '0;
        wr_ptr_d[i] = '0;
        count_d[i]  = '0;
      end
    end else if (rdy) begin
      // With no candidates, only cdb_valid drops. The payload fields keep
      // their old values.
      cdb_valid_d = grant_valid;
      if (grant_valid) begin
        cdb_src_d   = grant_idx;
        cdb_entry_d = grant_entry;
        rr_d        = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
      end
      for (int i = 0; i < NSRC; i++) begin
        if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
        if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count_d[i] = count_q[i] + 1'b1;
          2'b01:   count_d[i] = count_q[i] - 1'b1;
          default: count_d[i] = count_q[i];
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments, so every register in
  // the block samples its _d value from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= 2'd0;
      cdb_valid_q <= 1'b0;
      cdb_src_q   <= 2'd0;
      cdb_entry_q <= '0;
      for (int i = 0; i < NSRC; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      rr_q        <= rr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_src_q   <= cdb_src_d;
      cdb_entry_q <= cdb_entry_d;
      for (int i = 0; i < NSRC; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
    end
  end

  // NOTE: the FIFO storage has no reset. An entry is never read before it is
  // written, because count and the pointers are reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_entry[i];
    end
  end

  assign cdb_valid     = cdb_valid_q;
  assign cdb_src       = cdb_src_q;
  assign cdb_rob_entry = cdb_entry_q.rob_entry;
  assign cdb_value     = cdb_entry_q.value;
  assign cdb_need_jump = cdb_entry_q.need_jump;
  assign cdb_jump_pc   = cdb_entry_q.jump_pc;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Bench for cdb_arbiter. It applies a table of cycle vectors from reset and
// hand-written multi-cycle sequences (single result, fairness, backpressure,
// rollback, rdy stall, bypass). It then applies randomized traffic that is
// compared against a queue-based reference model. Build with CDB_BYPASS_EN
// defined to exercise the bypass variant.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int ROB_IDX_W  = 4;
  localparam int FIFO_DEPTH = 2;
`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                 clk, rst, rdy, rollback;
  logic                 alu_valid, alu_ready, alu_need_jump;
  logic [ROB_IDX_W-1:0] alu_rob_entry;
  logic [31:0]          alu_val, alu_jump_pc;
  logic                 lsb_valid, lsb_ready;
  logic [ROB_IDX_W-1:0] lsb_rob_entry;
  logic [31:0]          lsb_value;
  logic                 mul_valid, mul_ready;
  logic [ROB_IDX_W-1:0] mul_rob_entry;
  logic [31:0]          mul_val;
  logic                 cdb_valid, cdb_need_jump;
  logic [1:0]           cdb_src;
  logic [ROB_IDX_W-1:0] cdb_rob_entry;
  logic [31:0]          cdb_value, cdb_jump_pc;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.ROB_IDX_W(ROB_IDX_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rob_entry(alu_rob_entry),
    .alu_val(alu_val), .alu_need_jump(alu_need_jump), .alu_jump_pc(alu_jump_pc),
    .lsb_valid(lsb_valid), .lsb_ready(lsb_ready), .lsb_rob_entry(lsb_rob_entry),
    .lsb_value(lsb_value),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_rob_entry(mul_rob_entry),
    .mul_val(mul_val),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_rob_entry(cdb_rob_entry),
    .cdb_value(cdb_value), .cdb_need_jump(cdb_need_jump), .cdb_jump_pc(cdb_jump_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob;
    logic [31:0]          value;
    logic                 nj;
    logic [31:0]          pc;
  } m_entry_t;

  // One table row: inputs for a cycle and the CDB state expected after its edge.
  typedef struct {
    bit av; int ae;
    bit lv; int le;
    bit mv; int me;
    bit ev; int es; int ee;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; rollback = 1'b0;
    alu_valid = 1'b0; alu_rob_entry = '0; alu_val = '0; alu_need_jump = 1'b0; alu_jump_pc = '0;
    lsb_valid = 1'b0; lsb_rob_entry = '0; lsb_value = '0;
    mul_valid = 1'b0; mul_rob_entry = '0; mul_val = '0;
  endtask

  task automatic apply_rst();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_cdb(input string tag, input bit ev, input int es, input m_entry_t e);
    check({tag, ".valid"}, 64'(cdb_valid), 64'(ev));
    check({tag, ".src"},   64'(cdb_src), 64'(es));
    check({tag, ".rob"},   64'(cdb_rob_entry), 64'(e.rob));
    check({tag, ".value"}, 64'(cdb_value), 64'(e.value));
    check({tag, ".nj"},    64'(cdb_need_jump), 64'(e.nj));
    check({tag, ".pc"},    64'(cdb_jump_pc), 64'(e.pc));
  endtask

  // Reference model state
  m_entry_t mq [3][$];
  int       m_rr;
  bit       m_valid;
  int       m_src;
  m_entry_t m_e;

  initial begin
    vec_t     vecs [12];
    m_entry_t z;
    int       seen, first_low, accepts, post_rb, mul_id, got;
    bit       acc, saw6, saw5;
    int       acc_q[$];

    rst = 1'b1;
    idle_inputs();
    z = '0;

    // ---------------- Reset state ----------------
    apply_rst();
    check_cdb("reset", 1'b0, 0, z);
    check("reset.alu_ready", 64'(alu_ready), 64'd1);
    check("reset.lsb_ready", 64'(lsb_ready), 64'd1);
    check("reset.mul_ready", 64'(mul_ready), 64'd1);

`ifndef CDB_BYPASS_EN
    // ---------------- Table-driven sequence from reset ----------------
    // Values: ALU 0x100+e, LSB 0x200+e, MUL 0x300+e; ALU jump = e[0], pc 0x1000+e.
    vecs[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[3]  = '{0, 0, 1, 2, 1, 3, 0, 0, 1};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 1, 1, 2};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 1, 2, 3};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 2, 3};
    vecs[7]  = '{1, 4, 0, 0, 1, 5, 0, 2, 3};
    vecs[8]  = '{1, 6, 0, 0, 0, 0, 1, 0, 4};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 1, 2, 5};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 6};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 6};
    apply_rst();
    for (int i = 0; i < 12; i++) begin
      alu_valid = vecs[i].av; alu_rob_entry = 4'(vecs[i].ae); alu_val = 32'h100 + 32'(vecs[i].ae);
      alu_need_jump = vecs[i].ae[0]; alu_jump_pc = 32'h1000 + 32'(vecs[i].ae);
      lsb_valid = vecs[i].lv; lsb_rob_entry = 4'(vecs[i].le); lsb_value = 32'h200 + 32'(vecs[i].le);
      mul_valid = vecs[i].mv; mul_rob_entry = 4'(vecs[i].me); mul_val = 32'h300 + 32'(vecs[i].me);
      tick();
      check($sformatf("vec%0d.valid", i), 64'(cdb_valid), 64'(vecs[i].ev));
      check($sformatf("vec%0d.src", i), 64'(cdb_src), 64'(vecs[i].es));
      check($sformatf("vec%0d.rob", i), 64'(cdb_rob_entry), 64'(vecs[i].ee));
      if (vecs[i].ev) begin
        check($sformatf("vec%0d.value", i), 64'(cdb_value), 64'((vecs[i].es + 1) * 256 + vecs[i].ee));
        check($sformatf("vec%0d.nj", i), 64'(cdb_need_jump),
              64'((vecs[i].es == 0) ? (vecs[i].ee & 1) : 0));
        check($sformatf("vec%0d.pc", i), 64'(cdb_jump_pc),
              64'((vecs[i].es == 0) ? (32'h1000 + vecs[i].ee) : 0));
      end
    end
`endif

    // ---------------- Single result ----------------
    apply_rst();
    alu_valid = 1'b1; alu_rob_entry = 4'd3; alu_val = 32'h2A; alu_need_jump = 1'b1; alu_jump_pc = 32'h100;
    tick();
    idle_inputs();
`ifndef CDB_BYPASS_EN
    check("single.queued", 64'(cdb_valid), 64'd0);
    tick();
`endif
    check_cdb("single", 1'b1, 0, '{rob: 4'd3, value: 32'h2A, nj: 1'b1, pc: 32'h100});
    tick();
    check("single.after", 64'(cdb_valid), 64'd0);

    // ---------------- Fairness ----------------
    apply_rst();
    alu_valid = 1'b1; alu_rob_entry = 4'd1; alu_val = 32'h11;
    lsb_valid = 1'b1; lsb_rob_entry = 4'd2; lsb_value = 32'h22;
    mul_valid = 1'b1; mul_rob_entry = 4'd3; mul_val = 32'h33;
    seen = 0;
    for (int c = 0; c < 12 && seen < 6; c++) begin
      tick();
      if (cdb_valid) begin
        check($sformatf("fair%0d.src", seen), 64'(cdb_src), 64'(seen % 3));
        check($sformatf("fair%0d.rob", seen), 64'(cdb_rob_entry), 64'(seen % 3 + 1));
        seen++;
      end else if (seen > 0) begin
        check("fair.gap", 64'(cdb_valid), 64'd1);
      end
    end
    check("fair.count", 64'(seen), 64'd6);

    // ---------------- Backpressure on MUL ----------------
    apply_rst();
    alu_valid = 1'b1; alu_rob_entry = 4'd1;
    lsb_valid = 1'b1; lsb_rob_entry = 4'd2;
    mul_valid = 1'b1; mul_id = 1; mul_rob_entry = 4'(mul_id); mul_val = 32'h300 + 32'(mul_id);
    first_low = -1; accepts = 0; got = 0;
    acc_q.delete();
    for (int c = 0; c < 30; c++) begin
      acc = mul_ready;
      if (!acc && first_low < 0) first_low = accepts;
      tick();
      if (acc) begin
        acc_q.push_back(mul_id);
        accepts++;
        mul_id = (mul_id + 1) % 16;
        mul_rob_entry = 4'(mul_id); mul_val = 32'h300 + 32'(mul_id);
      end
      if (cdb_valid && cdb_src == 2'd2) begin
        got++;
        if (acc_q.size() == 0) check("bp.spurious", 64'd1, 64'd0);
        else check($sformatf("bp.order%0d", got), 64'(cdb_rob_entry), 64'(acc_q.pop_front()));
      end
    end
    check("bp.accepts_before_full", 64'(first_low), 64'(FIFO_DEPTH));
    check("bp.drained", 64'(got >= 9), 64'd1);
    check("bp.backlog", 64'(acc_q.size() <= FIFO_DEPTH), 64'd1);

    // ---------------- Rollback ----------------
    apply_rst();
    saw5 = 1'b0; saw6 = 1'b0;
    alu_valid = 1'b1; alu_rob_entry = 4'd1; lsb_valid = 1'b1; lsb_rob_entry = 4'd5;
    tick();
    if (cdb_valid && cdb_rob_entry == 4'd5) saw5 = 1'b1;
    alu_rob_entry = 4'd2; lsb_rob_entry = 4'd6;
    tick();
    if (cdb_valid && cdb_rob_entry == 4'd5) saw5 = 1'b1;
    if (cdb_valid && cdb_rob_entry == 4'd6) saw6 = 1'b1;
    rollback = 1'b1; lsb_valid = 1'b0; alu_rob_entry = 4'd7;
    tick();
    check("rb.valid", 64'(cdb_valid), 64'd0);
    idle_inputs();
    #1;
    check("rb.lsb_ready", 64'(lsb_ready), 64'd1);
    check("rb.alu_ready", 64'(alu_ready), 64'd1);
    post_rb = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (cdb_valid) post_rb++;
      if (cdb_valid && cdb_rob_entry == 4'd6) saw6 = 1'b1;
    end
    check("rb.post_broadcasts", 64'(post_rb), 64'd0);
    check("rb.entry6_seen", 64'(saw6), 64'd0);
`ifndef CDB_BYPASS_EN
    check("rb.entry5_seen", 64'(saw5), 64'd0);
`endif

    // ---------------- rdy stall ----------------
    apply_rst();
    alu_valid = 1'b1; alu_rob_entry = 4'd7; alu_val = 32'h77;
    mul_valid = 1'b1; mul_rob_entry = 4'd8; mul_val = 32'h88;
    tick();
    idle_inputs();
    got = 0;
    for (int c = 0; c < 4 && got == 0; c++) begin
      if (cdb_valid && cdb_rob_entry == 4'd7) got = 1;
      else tick();
    end
    check("stall.found7", 64'(got), 64'd1);
    rdy = 1'b0; lsb_valid = 1'b1; lsb_rob_entry = 4'd9;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("stall%0d.lsb_ready", c), 64'(lsb_ready), 64'd0);
      check($sformatf("stall%0d.mul_ready", c), 64'(mul_ready), 64'd0);
      tick();
      check_cdb($sformatf("stall%0d", c), 1'b1, 0, '{rob: 4'd7, value: 32'h77, nj: 1'b0, pc: 32'd0});
    end
    rdy = 1'b1; lsb_valid = 1'b0;
    tick();
    check_cdb("resume", 1'b1, 2, '{rob: 4'd8, value: 32'h88, nj: 1'b0, pc: 32'd0});
    tick();
    check("resume.idle", 64'(cdb_valid), 64'd0);

`ifdef CDB_BYPASS_EN
    // ---------------- Bypass ----------------
    apply_rst();
    lsb_valid = 1'b1; lsb_rob_entry = 4'd9; lsb_value = 32'h55;
    tick();
    idle_inputs();
    check_cdb("bypass", 1'b1, 1, '{rob: 4'd9, value: 32'h55, nj: 1'b0, pc: 32'd0});
    tick();
    check("bypass.fifo_empty", 64'(cdb_valid), 64'd0);
`endif

    // ---------------- Randomized traffic vs. reference model ----------------
    apply_rst();
    for (int s = 0; s < 3; s++) mq[s].delete();
    m_rr = 0; m_valid = 1'b0; m_src = 0; m_e = '0;
    for (int c = 0; c < 800; c++) begin
      bit       rdy_m[3];
      bit       off[3];
      bit       vin[3];
      m_entry_t inp[3];
      bit       granted, took;
      int       g;

      rdy      = ($urandom_range(0, 9) != 0);
      rollback = ($urandom_range(0, 39) == 0);
      alu_valid = 1'($urandom); alu_rob_entry = 4'($urandom); alu_val = $urandom;
      alu_need_jump = 1'($urandom); alu_jump_pc = $urandom;
      lsb_valid = 1'($urandom); lsb_rob_entry = 4'($urandom); lsb_value = $urandom;
      mul_valid = 1'($urandom); mul_rob_entry = 4'($urandom); mul_val = $urandom;
      #1;
      inp[0] = '{rob: alu_rob_entry, value: alu_val, nj: alu_need_jump, pc: alu_jump_pc};
      inp[1] = '{rob: lsb_rob_entry, value: lsb_value, nj: 1'b0, pc: 32'd0};
      inp[2] = '{rob: mul_rob_entry, value: mul_val, nj: 1'b0, pc: 32'd0};
      vin[0] = alu_valid; vin[1] = lsb_valid; vin[2] = mul_valid;
      for (int s = 0; s < 3; s++) begin
        rdy_m[s] = (mq[s].size() != FIFO_DEPTH) && rdy && !rollback;
        off[s]   = vin[s] && rdy_m[s];
      end
      check($sformatf("rnd%0d.alu_ready", c), 64'(alu_ready), 64'(rdy_m[0]));
      check($sformatf("rnd%0d.lsb_ready", c), 64'(lsb_ready), 64'(rdy_m[1]));
      check($sformatf("rnd%0d.mul_ready", c), 64'(mul_ready), 64'(rdy_m[2]));

      if (rollback) begin
        for (int s = 0; s < 3; s++) mq[s].delete();
        m_rr = 0; m_valid = 1'b0;
      end else if (rdy) begin
        granted = 1'b0; took = 1'b0; g = 0;
        for (int k = 0; k < 3; k++) begin
          int s;
          s = (m_rr + k) % 3;
          if (!granted && (mq[s].size() > 0 || (BYP && off[s]))) begin
            granted = 1'b1; g = s;
          end
        end
        if (granted) begin
          if (mq[g].size() > 0) m_e = mq[g].pop_front();
          else begin m_e = inp[g]; took = 1'b1; end
          m_valid = 1'b1; m_src = g; m_rr = (g + 1) % 3;
        end else begin
          m_valid = 1'b0;
        end
        for (int s = 0; s < 3; s++) begin
          if (off[s] && !(took && g == s)) mq[s].push_back(inp[s]);
        end
      end

      @(posedge clk);
      #1;
      check_cdb($sformatf("rnd%0d", c), m_valid, m_src, m_e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single ROB/RS result-writeback bus (CDB) among three producers: ALU, LSB and MUL.
- Each producer pushes results into its own small FIFO through a valid/ready handshake.
- A round-robin scheduler drains at most one entry per cycle onto a registered CDB.
- Sits between the execution units and the ROB's writeback port. Flushed on rollback.

Parameters:
- ROB_IDX_W, 4, width of a ROB entry index.
- FIFO_DEPTH, 2, entries per source FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rdy  in  1  global enable; low freezes all state
- rollback  in  1  misprediction flush
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU FIFO can accept
- alu_rob_entry  in  ROB_IDX_W  destination ROB entry
- alu_val  in  32  ALU result
- alu_need_jump  in  1  branch resolved taken
- alu_jump_pc  in  32  branch target or fall-through PC
- lsb_valid  in  1  load/store completion offered
- lsb_ready  out  1  LSB FIFO can accept
- lsb_rob_entry  in  ROB_IDX_W  destination ROB entry
- lsb_value  in  32  load data (0 for stores)
- mul_valid  in  1  MUL result offered
- mul_ready  out  1  MUL FIFO can accept
- mul_rob_entry  in  ROB_IDX_W  destination ROB entry
- mul_val  in  32  MUL result
- cdb_valid  out  1  broadcast this cycle
- cdb_src  out  2  00 ALU, 01 LSB, 10 MUL
- cdb_rob_entry  out  ROB_IDX_W  broadcast ROB entry
- cdb_value  out  32  broadcast value
- cdb_need_jump  out  1  ALU branch outcome; 0 for other sources
- cdb_jump_pc  out  32  ALU jump PC; 0 for other sources

Behaviour:
- Reset and handshake
  - Reset is rst, synchronous, active-high; clock is clk.
  - On rst, all FIFOs empty, rr pointer = 0, all cdb_* outputs = 0.
  - x_ready is combinational: (count_x != FIFO_DEPTH) && rdy && !rollback. It does not depend on a same-cycle pop.
  - A push occurs when x_valid && x_ready is sampled at the clock edge. The FIFO stores {rob_entry, value, need_jump, jump_pc}; LSB and MUL store need_jump = 0 and jump_pc = 0.
- Priority of conditions
  - rst overrides rollback, and rollback overrides rdy.
  - rollback: all FIFOs are emptied (read pointer, write pointer and count = 0), rr = 0, cdb_valid = 0, and same-cycle inputs are dropped.
  - rdy low: no push, no pop, and the cdb_* registers hold their values, including cdb_valid.
- Scheduling, each rdy cycle
  - Candidates are the sources with a non-empty FIFO. Scan order is rr, rr+1, rr+2, modulo 3. The first non-empty source is granted.
  - The grantee's head entry is popped and registered onto cdb_* with cdb_valid = 1. rr becomes (grant + 1) mod 3.
  - If there are no candidates, cdb_valid = 0, the other cdb_* fields keep their old values, and rr is unchanged.
- Latency: a result sampled at edge E0 appears on the CDB no earlier than edge E1 (one cycle in the FIFO). With all FIFOs idle, latency is exactly 1 cycle.
- FIFO mechanics
  - Circular buffers with log2(FIFO_DEPTH)-bit read and write pointers, which wrap naturally.
  - Count width is log2(FIFO_DEPTH)+1.
  - A simultaneous push and pop on the same FIFO leaves count unchanged. This case is only reachable when not full, because ready is computed pre-pop.
- Ordering: entries from one source broadcast in push order. No ordering is guaranteed across sources.
- Bandwidth and fairness: at most one broadcast per cycle. With all three FIFOs persistently non-empty, grants rotate ALU, LSB, MUL, ALU, and so on.

Optional Feature:
- CDB_BYPASS_EN
- Defined: if, at edge E0, the arbitration winner would be a source whose FIFO is empty but which is presenting x_valid && x_ready, its input is registered directly onto cdb_* at E0. This gives 0 cycles of queueing.
  - Arbitration then covers every source that is non-empty or offering input. A source with a non-empty FIFO always broadcasts its FIFO head, never its input.
  - A bypassed input is not written to the FIFO.
- Undefined: every result passes through its FIFO.

Test Plan:
- Single result: rst, then alu_valid=1, alu_rob_entry=3, alu_val=0x2A, alu_need_jump=1, alu_jump_pc=0x100 for one cycle -> one cycle later cdb_valid=1, cdb_src=00, cdb_rob_entry=3, cdb_value=0x2A, cdb_need_jump=1, cdb_jump_pc=0x100; the following cycle cdb_valid=0.
- Fairness: all three sources valid every cycle with entries 1/2/3 -> cdb_src sequence 00,01,10,00,01,10; no entry lost or duplicated.
- Backpressure: hold mul_valid with MUL always losing to continuous ALU/LSB traffic -> mul_ready deasserts after 2 accepts (FIFO_DEPTH=2); each MUL entry is still broadcast within 3 cycles of reaching FIFO head.
- Rollback: fill LSB FIFO with entries 5 and 6, then pulse rollback with alu_valid=1 -> the next cycle cdb_valid=0, the ALU input is dropped, LSB count=0, and no entry 5 or 6 is ever broadcast.
- rdy stall: a pending entry 7 on the CDB with rdy=0 for 4 cycles -> cdb_* unchanged, no pushes (x_ready=0), FIFO contents preserved; resumes in order when rdy=1.
- Bypass: with CDB_BYPASS_EN defined and all FIFOs empty, lsb_valid=1, lsb_rob_entry=9, lsb_value=0x55 -> cdb_valid=1, cdb_rob_entry=9, cdb_value=0x55 at the same edge; FIFO count stays 0.
